// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle HI/LO sequencer.
//   - operation encodings for DIV, DIVU, MADD, MADDU, MSUB, MSUBU
//   - controller state enum
//   - stall / ready level constants
//   - is_legal_op(): true for the six supported encodings
package muldiv_seq_pkg;

    typedef logic [2:0] mds_op_t;

    localparam mds_op_t MDS_OP_DIV   = 3'b000;
    localparam mds_op_t MDS_OP_DIVU  = 3'b001;
    localparam mds_op_t MDS_OP_MADD  = 3'b010;
    localparam mds_op_t MDS_OP_MADDU = 3'b011;
    localparam mds_op_t MDS_OP_MSUB  = 3'b100;
    localparam mds_op_t MDS_OP_MSUBU = 3'b101;

    typedef enum logic [2:0] {
        MDS_IDLE,
        MDS_DIV_ON,
        MDS_DIVZERO,
        MDS_MAC_ACC,
        MDS_DONE
    } mds_state_t;

    localparam logic MDS_STOP      = 1'b1;
    localparam logic MDS_NO_STOP   = 1'b0;
    localparam logic MDS_READY     = 1'b1;
    localparam logic MDS_NOT_READY = 1'b0;

    function automatic logic is_legal_op(input mds_op_t op);
        logic legal;
        case (op)
            MDS_OP_DIV, MDS_OP_DIVU, MDS_OP_MADD,
            MDS_OP_MADDU, MDS_OP_MSUB, MDS_OP_MSUBU: legal = 1'b1;
            default:                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and muldiv_seq.
//   master (EX side): drives start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i
//   slave (sequencer): drives result_o, ready_o, div_by_zero_o, busy_o, stallreq_o
interface muldiv_seq_if #(
    parameter int DATA_W = 32
);
    import muldiv_seq_pkg::*;

    logic                  start_i;
    mds_op_t               op_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic [2*DATA_W-1:0]   hilo_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  div_by_zero_o;
    logic                  busy_o;
    logic                  stallreq_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        input  result_o, ready_o, div_by_zero_o, busy_o, stallreq_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
        output result_o, ready_o, div_by_zero_o, busy_o, stallreq_o
    );

endinterface

// File: rtl/muldiv_seq_div_step.sv
// One combinational restoring-division iteration.
//   rem_i     : partial remainder (always < divisor_i)
//   bit_i     : next dividend bit shifted in
//   divisor_i : divisor magnitude
//   rem_o     : new partial remainder
//   q_o       : quotient bit produced by this iteration
module muldiv_seq_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // shifted < 2*divisor, so the sign of diff fits in the extra top bit
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[DATA_W]) begin
            rem_o = diff[DATA_W-1:0];
            q_o   = 1'b1;
        end else begin
            rem_o = shifted[DATA_W-1:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle sequencer for DIV/DIVU and MADD/MADDU/MSUB/MSUBU.
// Holds the pipeline with stallreq_o until the {HI,LO} result is ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_seq_if slave port carrying the request (start_i, op_i,
//              opdata1_i, opdata2_i, hilo_i, annul_i) and the response
//              (result_o, ready_o, div_by_zero_o, busy_o, stallreq_o)
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(DATA_W);

    mds_state_t            state;
    logic [CNT_W-1:0]      count;
    logic [DATA_W-1:0]     rem_q;
    logic [DATA_W-1:0]     quo_q;
    logic [DATA_W-1:0]     divisor_q;
    logic                  neg_quo_q;
    logic                  neg_rem_q;
    logic [2*DATA_W-1:0]   prod_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;
    logic                  dbz_q;

    logic                  accept;
    logic                  op_is_div;
    logic                  op_signed_div;
    logic                  op_signed_mac;
    logic                  op_is_sub;
    logic [DATA_W-1:0]     abs_a;
    logic [DATA_W-1:0]     abs_b;
    logic [2*DATA_W-1:0]   ext_a;
    logic [2*DATA_W-1:0]   ext_b;
    logic [2*DATA_W-1:0]   product;
    logic [2*DATA_W-1:0]   mac_product;

    logic [DATA_W-1:0]     step_rem;
    logic                  step_q;
    logic [DATA_W-1:0]     raw_quo;
    logic [DATA_W-1:0]     final_quo;
    logic [DATA_W-1:0]     final_rem;

    // Operand preparation for whichever op is being accepted in IDLE.
    // The low 2*DATA_W bits of a sign- or zero-extended product are the
    // correct two's-complement result for both signednesses.
    always_comb begin
        accept        = bus.start_i & is_legal_op(bus.op_i) & ~bus.annul_i;
        op_is_div     = (bus.op_i == MDS_OP_DIV) || (bus.op_i == MDS_OP_DIVU);
        op_signed_div = (bus.op_i == MDS_OP_DIV);
        op_signed_mac = (bus.op_i == MDS_OP_MADD) || (bus.op_i == MDS_OP_MSUB);
        op_is_sub     = (bus.op_i == MDS_OP_MSUB) || (bus.op_i == MDS_OP_MSUBU);

        abs_a = (op_signed_div && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
        abs_b = (op_signed_div && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

        ext_a = {{DATA_W{op_signed_mac & bus.opdata1_i[DATA_W-1]}}, bus.opdata1_i};
        ext_b = {{DATA_W{op_signed_mac & bus.opdata2_i[DATA_W-1]}}, bus.opdata2_i};
        product     = ext_a * ext_b;
        mac_product = op_is_sub ? -product : product;
    end

    // Dividend bits stream out of the top of quo_q while quotient bits
    // shift in at the bottom, so quo_q ends up holding the quotient.
    muldiv_seq_div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[DATA_W-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Sign fix-up applied on the final iteration: the quotient is negated
    // when operand signs differ, the remainder follows the dividend.
    always_comb begin
        raw_quo   = {quo_q[DATA_W-2:0], step_q};
        final_quo = neg_quo_q ? -raw_quo : raw_quo;
        final_rem = neg_rem_q ? -step_rem : step_rem;
    end

    // Controller. An annul or a dropped start_i in any active state returns
    // to IDLE and clears the outputs, taking priority over a completing step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MDS_IDLE;
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            prod_q    <= '0;
            result_q  <= '0;
            ready_q   <= MDS_NOT_READY;
            dbz_q     <= 1'b0;
        end else if (state != MDS_IDLE && (bus.annul_i || !bus.start_i)) begin
            state    <= MDS_IDLE;
            count    <= '0;
            result_q <= '0;
            ready_q  <= MDS_NOT_READY;
            dbz_q    <= 1'b0;
        end else begin
            case (state)
                MDS_IDLE: begin
                    if (accept) begin
                        count     <= '0;
                        rem_q     <= '0;
                        quo_q     <= abs_a;
                        divisor_q <= abs_b;
                        neg_quo_q <= op_signed_div & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                        neg_rem_q <= op_signed_div & bus.opdata1_i[DATA_W-1];
                        prod_q    <= mac_product;
                        if (op_is_div) begin
                            state <= (bus.opdata2_i == '0) ? MDS_DIVZERO : MDS_DIV_ON;
                        end else begin
                            state <= MDS_MAC_ACC;
                        end
                    end
                end
                MDS_DIV_ON: begin
                    rem_q <= step_rem;
                    quo_q <= raw_quo;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        result_q <= {final_rem, final_quo};
                        ready_q  <= MDS_READY;
                        state    <= MDS_DONE;
                    end
                end
                MDS_DIVZERO: begin
                    result_q <= '0;
                    dbz_q    <= 1'b1;
                    ready_q  <= MDS_READY;
                    state    <= MDS_DONE;
                end
                MDS_MAC_ACC: begin
                    result_q <= prod_q + bus.hilo_i;
                    ready_q  <= MDS_READY;
                    state    <= MDS_DONE;
                end
                MDS_DONE: begin
                    state <= MDS_DONE;
                end
                default: begin
                    state <= MDS_IDLE;
                end
            endcase
        end
    end

    assign bus.result_o      = result_q;
    assign bus.ready_o       = ready_q;
    assign bus.div_by_zero_o = dbz_q;
    assign bus.busy_o        = (state != MDS_IDLE);
    assign bus.stallreq_o    = (accept && state != MDS_DONE) ? MDS_STOP : MDS_NO_STOP;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: a table of directed operations with
// hand-computed results and latencies, plus sequences for annul, mid-op
// reset, start_i withdrawal and illegal opcodes.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int DATA_W = 32;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] result;
        logic        dbz;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[12];

    muldiv_seq_if #(.DATA_W(DATA_W)) bus ();

    muldiv_seq #(
        .DATA_W (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Runs one operation to completion, holds it one extra cycle in DONE,
    // then withdraws start_i. With scramble set, op/operands are altered
    // right after acceptance.
    task automatic applyStimulus(input vec_t v, input bit scramble, input string tag);
        int cycles;
        bit got;
        int stall_bad;
        @(negedge clk);
        bus.op_i      = v.op;
        bus.opdata1_i = v.a;
        bus.opdata2_i = v.b;
        bus.hilo_i    = v.hilo;
        bus.annul_i   = 1'b0;
        bus.start_i   = 1'b1;
        cycles    = 0;
        got       = 1'b0;
        stall_bad = 0;
        while (!got && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.ready_o === 1'b1) begin
                got = 1'b1;
            end else begin
                if (bus.stallreq_o !== 1'b1 || bus.busy_o !== 1'b1) stall_bad++;
                if (scramble && cycles == 1) begin
                    bus.op_i      = MDS_OP_MADD;
                    bus.opdata1_i = ~v.a;
                    bus.opdata2_i = 32'h0000_0001;
                end
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: actual=no ready required=ready within 100 cycles", tag);
            bus.start_i = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        checkOutput({tag, " latency"}, 64'(cycles), 64'(v.lat));
        checkOutput({tag, " result"}, bus.result_o, v.result);
        checkOutput({tag, " dbz"}, 64'(bus.div_by_zero_o), 64'(v.dbz));
        checkOutput({tag, " stall before ready"}, 64'(stall_bad), 64'd0);
        checkOutput({tag, " stall in done"}, 64'(bus.stallreq_o), 64'd0);
        checkOutput({tag, " busy in done"}, 64'(bus.busy_o), 64'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, " held result"}, bus.result_o, v.result);
        checkOutput({tag, " held ready"}, 64'(bus.ready_o), 64'd1);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, " cleared"}, {bus.result_o[61:0], bus.ready_o, bus.div_by_zero_o}, 64'd0);
        checkOutput({tag, " idle"}, 64'(bus.busy_o), 64'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{MDS_OP_DIV,   32'd7,          32'hFFFF_FFFE, 64'h0,                   64'h0000_0001_FFFF_FFFD, 1'b0, 33};
        vecs[1]  = '{MDS_OP_DIVU,  32'hFFFF_FFFF,  32'h0000_0010, 64'h0,                   64'h0000_000F_0FFF_FFFF, 1'b0, 33};
        vecs[2]  = '{MDS_OP_DIV,   32'd5,          32'd0,         64'h0,                   64'h0,                   1'b1, 2};
        vecs[3]  = '{MDS_OP_MADD,  32'hFFFF_FFFE,  32'd3,         64'h10,                  64'h0000_0000_0000_000A, 1'b0, 2};
        vecs[4]  = '{MDS_OP_MSUBU, 32'd2,          32'd3,         64'h10,                  64'h0000_0000_0000_000A, 1'b0, 2};
        vecs[5]  = '{MDS_OP_MSUB,  32'hFFFF_FFFF,  32'd1,         64'h0,                   64'h0000_0000_0000_0001, 1'b0, 2};
        vecs[6]  = '{MDS_OP_DIV,   32'hFFFF_FFF9,  32'd2,         64'h0,                   64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33};
        vecs[7]  = '{MDS_OP_DIVU,  32'd100,        32'd7,         64'h0,                   64'h0000_0002_0000_000E, 1'b0, 33};
        vecs[8]  = '{MDS_OP_MADDU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h1,                   64'hFFFF_FFFE_0000_0002, 1'b0, 2};
        vecs[9]  = '{MDS_OP_MADD,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b0, 2};
        vecs[10] = '{MDS_OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 64'h0,                   64'h0000_0000_8000_0000, 1'b0, 33};
        vecs[11] = '{MDS_OP_DIVU,  32'd3,          32'd5,         64'h0,                   64'h0000_0003_0000_0000, 1'b0, 33};

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.op_i      = MDS_OP_DIV;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.hilo_i    = '0;
        bus.annul_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset result", bus.result_o, 64'd0);
        checkOutput("reset flags", {61'd0, bus.ready_o, bus.div_by_zero_o, bus.busy_o}, 64'd0);
        checkOutput("reset stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], 1'b0, $sformatf("v%0d", i));
        end

        // annul part-way through a divide, then a fresh divide with
        // inputs disturbed after acceptance
        @(negedge clk);
        bus.op_i      = MDS_OP_DIV;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("annul pre busy", 64'(bus.busy_o), 64'd1);
        @(negedge clk);
        bus.annul_i = 1'b1;
        #1;
        checkOutput("annul stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("annul idle", {62'd0, bus.busy_o, bus.ready_o}, 64'd0);
        checkOutput("annul result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        v = '{MDS_OP_DIVU, 32'd9, 32'd2, 64'h0, 64'h0000_0001_0000_0004, 1'b0, 33};
        applyStimulus(v, 1'b1, "after annul");

        // synchronous reset in the middle of a divide
        @(negedge clk);
        bus.op_i      = MDS_OP_DIV;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd7;
        bus.start_i   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midop reset flags", {61'd0, bus.ready_o, bus.div_by_zero_o, bus.busy_o}, 64'd0);
        checkOutput("midop reset result", bus.result_o, 64'd0);
        @(negedge clk);
        rst      = 1'b0;
        bus.op_i = 3'b111;
        #1;
        checkOutput("illegal stall", 64'(bus.stallreq_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("illegal busy", {62'd0, bus.busy_o, bus.ready_o}, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;

        // EX withdraws start_i before the divide completes
        @(negedge clk);
        bus.op_i      = MDS_OP_DIVU;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("start drop idle", {62'd0, bus.busy_o, bus.ready_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
